consumer_checker: RTL and testbench
===================================

CONSUMER_CHECKER -- requirements
Module: consumer_checker

Interface
REQ-001 Parameter DATA_W, default 32, lane data width.
REQ-002 Parameter CNT_W, default 16, width of the receive and error counters.
REQ-003 Parameter LFSR_SEED, default 16'hACE1, nonzero LFSR reset value.
REQ-004 Parameter MAX_STALL, default 4, maximum number of consecutive stall cycles per lane (range 1..15).
REQ-005 clk  input  1  clock; all state changes on the rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 stall_en  input  1  enables stall generation; when low, both stall outputs are 0.
REQ-008 out_valid  input  2  per-lane valid from the pipeline outputs (bit0 = lane 1, bit1 = lane 2).
REQ-009 out_data_1, out_data_2  input  DATA_W  lane output data.
REQ-010 flush_1, flush_2  input  1  per-lane flush pulse.
REQ-011 stall_1, stall_2  output  1  registered per-lane back-pressure to the producer and pipeline.
REQ-012 rx_count_1, rx_count_2  output  CNT_W  valid words received per lane, saturating.
REQ-013 err_count_1, err_count_2  output  CNT_W  mismatches per lane, saturating.
REQ-014 err_sticky  output  2  per-lane sticky error flag.
REQ-015 first_err_lane  output  2  one-hot lane of the first mismatch since reset; 0 if none.
REQ-016 first_err_data, first_err_exp  output  DATA_W  received and expected values of the first mismatch.

Function
REQ-017 Each lane SHALL run an independent two-state FSM: SYNC (waiting for a reference word) and CHECK.
REQ-018 SYNC with out_valid[i]=1: no compare; expected_i <= data+2; rx_count_i increments; go to CHECK.
REQ-019 CHECK with out_valid[i]=1 and data==expected_i: rx_count_i increments; expected_i <= expected_i+2, modulo 2^DATA_W (wrap 0xFFFFFFFE -> 0x00000000 is legal).
REQ-020 CHECK with out_valid[i]=1 and data!=expected_i: rx_count_i and err_count_i increment; err_sticky[i] <= 1; expected_i <= data+2 (resync, no error cascade).
REQ-021 A mismatch SHALL capture first_err_lane, first_err_data and first_err_exp only while first_err_lane==0.
REQ-022 If both lanes mismatch in the same cycle, lane 1 SHALL be captured.
REQ-023 flush_i=1 SHALL force lane i to SYNC on the next edge.
REQ-024 If flush_i and out_valid[i] are high in the same cycle, the word SHALL be counted in rx_count_i and not compared.
REQ-025 Valid words SHALL be consumed regardless of the stall outputs; stall only throttles upstream.
REQ-026 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-027 16-bit Fibonacci LFSR, taps 16,14,13,11: shift every cycle while stall_en=1; hold while stall_en=0.
REQ-028 Raw stall request: lane 1 = lfsr[0], lane 2 = lfsr[1].
REQ-029 Per-lane run counter of consecutive asserted stall cycles.
REQ-030 When the run counter reaches MAX_STALL, stall_i SHALL be 0 for at least one cycle and the run counter SHALL clear.
REQ-031 stall_i SHALL be 1 only when the raw request is 1, stall_en=1, and the run limit is not reached.

Reset
REQ-032 Reset SHALL set stall_1=0, stall_2=0, all counters=0, err_sticky=0, first_err_lane=0, first_err_data=0, first_err_exp=0, expected_i=0, both FSMs=SYNC, lfsr=LFSR_SEED, run counters=0.
REQ-033 Reset asserted mid-stream SHALL take effect immediately, independent of clk.
REQ-034 After reset, the first valid word on each lane SHALL be treated as a SYNC reference.

Verification
REQ-035 Clean stream: lane1 0,2,4,6, lane2 1,3,5,7 -> rx_count=4/4, err_count=0/0, err_sticky=00.
REQ-036 Corrupt word: lane1 0,2,9,11 -> err_count_1=1, first_err_lane=01, first_err_data=9, first_err_exp=4, no further errors.
REQ-037 Flush resync: lane2 1,3, flush_2, then 41,43 -> err_count_2=0, rx_count_2=4.
REQ-038 Wrap: lane1 0xFFFFFFFC, 0xFFFFFFFE, 0x00000000 -> err_count_1=0.
REQ-039 Stall limit: stall_en=1 with seed forcing lfsr[0]=1 -> stall_1 never high more than 4 consecutive cycles; stall_en=0 -> stall_1=stall_2=0 next cycle.
REQ-040 Simultaneous mismatch on both lanes -> first_err_lane=01, both err_sticky bits set; reset mid-run -> all outputs return to REQ-032 values.

Source files
------------

// File: rtl/consumer_checker.sv
// Two-lane output checker: verifies each lane carries an incrementing-by-2 stream,
// counts words and mismatches, and generates bounded pseudo-random back-pressure.
module consumer_checker #(
  parameter int          DATA_W    = 32,
  parameter int          CNT_W     = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          MAX_STALL = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_en,
  input  logic [1:0]        out_valid,
  input  logic [DATA_W-1:0] out_data_1,
  input  logic [DATA_W-1:0] out_data_2,
  input  logic              flush_1,
  input  logic              flush_2,
  output logic              stall_1,
  output logic              stall_2,
  output logic [CNT_W-1:0]  rx_count_1,
  output logic [CNT_W-1:0]  rx_count_2,
  output logic [CNT_W-1:0]  err_count_1,
  output logic [CNT_W-1:0]  err_count_2,
  output logic [1:0]        err_sticky,
  output logic [1:0]        first_err_lane,
  output logic [DATA_W-1:0] first_err_data,
  output logic [DATA_W-1:0] first_err_exp
);

  localparam logic [0:0] SYNC  = 1'b0;
  localparam logic [0:0] CHECK = 1'b1;

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [3:0]       RUN_LIMIT = 4'(MAX_STALL);

  logic [0:0]        state_q   [2];
  logic [DATA_W-1:0] exp_q     [2];
  logic [CNT_W-1:0]  rx_q      [2];
  logic [CNT_W-1:0]  err_q     [2];
  logic [3:0]        run_q     [2];
  logic [1:0]        stall_q;
  logic [15:0]       lfsr_q;

  logic [DATA_W-1:0] data_in   [2];
  logic [1:0]        flush_in;
  logic [1:0]        mismatch;
  logic [1:0]        raw_stall;
  logic              lfsr_fb;

  assign data_in[0] = out_data_1;
  assign data_in[1] = out_data_2;
  assign flush_in   = {flush_2, flush_1};

  // A word arriving with a flush is counted but never compared.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    mismatch = 2'b00;
    for (int i = 0; i < 2; i++) begin
      mismatch[i] = out_valid[i] && !flush_in[i] && (state_q[i] == CHECK) &&
                    (data_in[i] != exp_q[i]);
    end
  end

  // Right-shifting Fibonacci form of taps 16,14,13,11; bit 0 is the oldest output bit.
  assign lfsr_fb   = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
  assign raw_stall = lfsr_q[1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= SYNC;
        exp_q[i]   <= '0;
        rx_q[i]    <= '0;
        err_q[i]   <= '0;
      end
      err_sticky     <= 2'b00;
      first_err_lane <= 2'b00;
      first_err_data <= '0;
      first_err_exp  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every lane sees pre-edge values.
      for (int i = 0; i < 2; i++) begin
        if (out_valid[i] && (rx_q[i] != CNT_MAX)) rx_q[i] <= rx_q[i] + CNT_W'(1);
        if (flush_in[i]) begin
          state_q[i] <= SYNC;
        end else if (out_valid[i]) begin
          // Match or mismatch, the next expected word follows the received one.
          exp_q[i]   <= data_in[i] + DATA_W'(2);
          state_q[i] <= CHECK;
        end
        if (mismatch[i]) begin
          err_sticky[i] <= 1'b1;
          if (err_q[i] != CNT_MAX) err_q[i] <= err_q[i] + CNT_W'(1);
        end
      end
      if (first_err_lane == 2'b00) begin
        if (mismatch[0]) begin
          first_err_lane <= 2'b01;
          first_err_data <= data_in[0];
          first_err_exp  <= exp_q[0];
        end else if (mismatch[1]) begin
          first_err_lane <= 2'b10;
          first_err_data <= data_in[1];
          first_err_exp  <= exp_q[1];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q  <= LFSR_SEED;
      stall_q <= 2'b00;
      for (int i = 0; i < 2; i++) run_q[i] <= '0;
    end else begin
      if (stall_en) lfsr_q <= {lfsr_fb, lfsr_q[15:1]};
      // A run that reaches the limit forces one released cycle before stalling again.
      for (int i = 0; i < 2; i++) begin
        if (stall_en && raw_stall[i] && (run_q[i] != RUN_LIMIT)) begin
          stall_q[i] <= 1'b1;
          run_q[i]   <= run_q[i] + 4'd1;
        end else begin
          stall_q[i] <= 1'b0;
          run_q[i]   <= '0;
        end
      end
    end
  end

  assign stall_1     = stall_q[0];
  assign stall_2     = stall_q[1];
  assign rx_count_1  = rx_q[0];
  assign rx_count_2  = rx_q[1];
  assign err_count_1 = err_q[0];
  assign err_count_2 = err_q[1];

endmodule

// File: tb/tb_consumer_checker.sv
// Directed bench for consumer_checker: stream checking, flush, wrap, saturation,
// first-error capture, bounded stall generation and asynchronous reset.
module tb_consumer_checker;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              stall_en;
  logic [1:0]        out_valid;
  logic [DATA_W-1:0] out_data_1, out_data_2;
  logic              flush_1, flush_2;
  logic              stall_1, stall_2;
  logic [CNT_W-1:0]  rx_count_1, rx_count_2, err_count_1, err_count_2;
  logic [1:0]        err_sticky, first_err_lane;
  logic [DATA_W-1:0] first_err_data, first_err_exp;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  consumer_checker #(
    .DATA_W(DATA_W), .CNT_W(CNT_W), .LFSR_SEED(16'hFFFF), .MAX_STALL(4)
  ) dut (
    .clk(clk), .reset(reset), .stall_en(stall_en), .out_valid(out_valid),
    .out_data_1(out_data_1), .out_data_2(out_data_2),
    .flush_1(flush_1), .flush_2(flush_2),
    .stall_1(stall_1), .stall_2(stall_2),
    .rx_count_1(rx_count_1), .rx_count_2(rx_count_2),
    .err_count_1(err_count_1), .err_count_2(err_count_2),
    .err_sticky(err_sticky), .first_err_lane(first_err_lane),
    .first_err_data(first_err_data), .first_err_exp(first_err_exp)
  );

  // Inputs change on the falling edge; outputs are sampled on the falling edge.
  task automatic step(input logic [1:0] v, input logic [DATA_W-1:0] d1,
                      input logic [DATA_W-1:0] d2, input logic [1:0] f);
    out_valid = v; out_data_1 = d1; out_data_2 = d2; flush_1 = f[0]; flush_2 = f[1];
    @(posedge clk); @(negedge clk);
    out_valid = 2'b00; flush_1 = 1'b0; flush_2 = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1; stall_en = 1'b0; out_valid = 2'b00; flush_1 = 1'b0; flush_2 = 1'b0;
    out_data_1 = '0; out_data_2 = '0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if ({stall_1, stall_2} !== 2'b00 || rx_count_1 !== '0 || rx_count_2 !== '0 ||
        err_count_1 !== '0 || err_count_2 !== '0 || err_sticky !== 2'b00 ||
        first_err_lane !== 2'b00 || first_err_data !== '0 || first_err_exp !== '0) begin
      fails++;
      $display("FAIL %s: got stall=%b%b rx=%0d/%0d err=%0d/%0d sticky=%b lane=%b data=%h exp=%h, want all zero",
               tag, stall_1, stall_2, rx_count_1, rx_count_2, err_count_1, err_count_2,
               err_sticky, first_err_lane, first_err_data, first_err_exp);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    check_reset_values("reset_state");
  endtask

  task automatic test_clean();
    apply_reset();
    for (int k = 0; k < 4; k++) step(2'b11, 32'(2 * k), 32'(2 * k + 1), 2'b00);
    checks++;
    if (rx_count_1 !== 4'd4 || rx_count_2 !== 4'd4) begin
      fails++; $display("FAIL clean_rx: got %0d/%0d want 4/4", rx_count_1, rx_count_2);
    end
    checks++;
    if (err_count_1 !== 4'd0 || err_count_2 !== 4'd0 || err_sticky !== 2'b00 || first_err_lane !== 2'b00) begin
      fails++; $display("FAIL clean_err: got err=%0d/%0d sticky=%b lane=%b want 0/0 00 00",
                        err_count_1, err_count_2, err_sticky, first_err_lane);
    end
  endtask

  task automatic test_corrupt();
    apply_reset();
    step(2'b01, 32'd0, '0, 2'b00);
    step(2'b01, 32'd2, '0, 2'b00);
    step(2'b01, 32'd9, '0, 2'b00);
    step(2'b01, 32'd11, '0, 2'b00);
    checks++;
    if (err_count_1 !== 4'd1 || rx_count_1 !== 4'd4 || err_sticky !== 2'b01) begin
      fails++; $display("FAIL corrupt_counts: got err=%0d rx=%0d sticky=%b want 1 4 01",
                        err_count_1, rx_count_1, err_sticky);
    end
    checks++;
    if (first_err_lane !== 2'b01 || first_err_data !== 32'd9 || first_err_exp !== 32'd4) begin
      fails++; $display("FAIL corrupt_capture: got lane=%b data=%0d exp=%0d want 01 9 4",
                        first_err_lane, first_err_data, first_err_exp);
    end
  endtask

  task automatic test_flush();
    apply_reset();
    step(2'b10, '0, 32'd1, 2'b00);
    step(2'b10, '0, 32'd3, 2'b00);
    step(2'b00, '0, '0, 2'b10);
    step(2'b10, '0, 32'd41, 2'b00);
    step(2'b10, '0, 32'd43, 2'b00);
    checks++;
    if (err_count_2 !== 4'd0 || rx_count_2 !== 4'd4) begin
      fails++; $display("FAIL flush_resync: got err=%0d rx=%0d want 0 4", err_count_2, rx_count_2);
    end
    // A word that arrives together with its flush is counted but not compared.
    apply_reset();
    step(2'b01, 32'd0, '0, 2'b00);
    step(2'b01, 32'd7, '0, 2'b01);
    step(2'b01, 32'd100, '0, 2'b00);
    step(2'b01, 32'd102, '0, 2'b00);
    checks++;
    if (err_count_1 !== 4'd0 || rx_count_1 !== 4'd4 || err_sticky !== 2'b00) begin
      fails++; $display("FAIL flush_with_valid: got err=%0d rx=%0d sticky=%b want 0 4 00",
                        err_count_1, rx_count_1, err_sticky);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    step(2'b01, 32'hFFFF_FFFC, '0, 2'b00);
    step(2'b01, 32'hFFFF_FFFE, '0, 2'b00);
    step(2'b01, 32'h0000_0000, '0, 2'b00);
    checks++;
    if (err_count_1 !== 4'd0 || rx_count_1 !== 4'd3) begin
      fails++; $display("FAIL wrap: got err=%0d rx=%0d want 0 3", err_count_1, rx_count_1);
    end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    step(2'b11, 32'd0, 32'd0, 2'b00);
    step(2'b11, 32'd5, 32'd6, 2'b00);
    checks++;
    if (first_err_lane !== 2'b01 || first_err_data !== 32'd5 || first_err_exp !== 32'd2) begin
      fails++; $display("FAIL simul_capture: got lane=%b data=%0d exp=%0d want 01 5 2",
                        first_err_lane, first_err_data, first_err_exp);
    end
    checks++;
    if (err_sticky !== 2'b11 || err_count_1 !== 4'd1 || err_count_2 !== 4'd1) begin
      fails++; $display("FAIL simul_sticky: got sticky=%b err=%0d/%0d want 11 1/1",
                        err_sticky, err_count_1, err_count_2);
    end
    step(2'b10, '0, 32'd20, 2'b00);
    checks++;
    if (first_err_lane !== 2'b01 || first_err_data !== 32'd5 || err_count_2 !== 4'd2) begin
      fails++; $display("FAIL capture_once: got lane=%b data=%0d err2=%0d want 01 5 2",
                        first_err_lane, first_err_data, err_count_2);
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    for (int k = 0; k < 21; k++) step(2'b01, 32'd5, '0, 2'b00);
    checks++;
    if (rx_count_1 !== 4'd15 || err_count_1 !== 4'd15) begin
      fails++; $display("FAIL saturate: got rx=%0d err=%0d want 15 15", rx_count_1, err_count_1);
    end
  endtask

  task automatic test_stall();
    logic [9:0] pattern;
    int run1, run2, worst1, worst2;
    apply_reset();
    pattern = 10'b0111101111;
    stall_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if (stall_1 !== pattern[k] || stall_2 !== pattern[k]) begin
        fails++; $display("FAIL stall_pattern[%0d]: got %b%b want %b%b", k, stall_1, stall_2,
                          pattern[k], pattern[k]);
      end
    end
    run1 = 0; run2 = 0; worst1 = 0; worst2 = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); @(negedge clk);
      run1 = stall_1 ? run1 + 1 : 0;
      run2 = stall_2 ? run2 + 1 : 0;
      if (run1 > worst1) worst1 = run1;
      if (run2 > worst2) worst2 = run2;
    end
    checks++;
    if (worst1 > 4 || worst2 > 4) begin
      fails++; $display("FAIL stall_run_limit: got longest %0d/%0d want <= 4", worst1, worst2);
    end
    stall_en = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++;
    if (stall_1 !== 1'b0 || stall_2 !== 1'b0) begin
      fails++; $display("FAIL stall_disable: got %b%b want 00", stall_1, stall_2);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    stall_en = 1'b1;
    step(2'b11, 32'd0, 32'd0, 2'b00);
    step(2'b11, 32'd9, 32'd9, 2'b00);
    checks++;
    if (stall_1 !== 1'b1 || err_sticky !== 2'b11) begin
      fails++; $display("FAIL pre_reset_state: got stall1=%b sticky=%b want 1 11", stall_1, err_sticky);
    end
    #2 reset = 1'b1;
    #1 check_reset_values("async_reset");
    @(negedge clk);
    reset = 1'b0; stall_en = 1'b0;
    step(2'b01, 32'd50, '0, 2'b00);
    step(2'b01, 32'd52, '0, 2'b00);
    checks++;
    if (err_count_1 !== 4'd0 || rx_count_1 !== 4'd2) begin
      fails++; $display("FAIL post_reset_sync: got err=%0d rx=%0d want 0 2", err_count_1, rx_count_1);
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_corrupt();
    test_flush();
    test_wrap();
    test_simultaneous();
    test_saturation();
    test_stall();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
